// File: rtl/rob_param_if.sv
`default_nettype none
// ============================================================================
// Module   : rob_param_if
// Purpose  : Dispatch / writeback / lookup / commit bundle of the reorder buffer.
// Revision : 1.0  initial release
// ============================================================================
interface rob_param_if #(
    parameter int DEPTH    = 32,
    parameter int WB_PORTS = 4
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [4:0]               alloc_rd_addr;
    logic                     alloc_regf_we;
    logic [31:0]              alloc_pc;
    logic [IDX_W-1:0]         alloc_idx;

    logic [WB_PORTS-1:0]      wb_valid;
    logic [WB_PORTS*IDX_W-1:0] wb_idx;
    logic [WB_PORTS*32-1:0]   wb_data;
    logic [WB_PORTS-1:0]      wb_mispredict;
    logic [WB_PORTS*32-1:0]   wb_pc_new;

    logic [2*IDX_W-1:0]       lk_idx;
    logic [1:0]               lk_ready;
    logic [63:0]              lk_data;

    logic [1:0]               commit_valid;
    logic [9:0]               commit_rd_addr;
    logic [63:0]              commit_data;
    logic [1:0]               commit_regf_we;
    logic [2*IDX_W-1:0]       commit_idx;

    logic                     flush;
    logic [31:0]              flush_pc;

    modport master (
        output alloc_valid, alloc_rd_addr, alloc_regf_we, alloc_pc,
        output wb_valid, wb_idx, wb_data, wb_mispredict, wb_pc_new, lk_idx,
        input  alloc_ready, alloc_idx, lk_ready, lk_data,
        input  commit_valid, commit_rd_addr, commit_data, commit_regf_we, commit_idx,
        input  flush, flush_pc
    );

    modport slave (
        input  alloc_valid, alloc_rd_addr, alloc_regf_we, alloc_pc,
        input  wb_valid, wb_idx, wb_data, wb_mispredict, wb_pc_new, lk_idx,
        output alloc_ready, alloc_idx, lk_ready, lk_data,
        output commit_valid, commit_rd_addr, commit_data, commit_regf_we, commit_idx,
        output flush, flush_pc
    );
endinterface
`default_nettype wire

// File: rtl/rob_param.sv
`default_nettype none
// ============================================================================
// Module   : rob_param
// Purpose  : Parameterised reorder buffer, in-order commit, flush on retired
//            mispredict. Define ROB_DUAL_COMMIT_EN for a second commit slot.
// Revision : 1.0  initial release
// ============================================================================
module rob_param #(
    parameter int DEPTH    = 32,
    parameter int WB_PORTS = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rob_param_if.slave rob
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2
    } entry_st_t;

    entry_st_t        r_state  [DEPTH];
    logic [31:0]      r_data   [DEPTH];
    logic [4:0]       r_rd     [DEPTH];
    logic             r_we     [DEPTH];
    logic             r_misp   [DEPTH];
    logic [31:0]      r_pc_new [DEPTH];
    logic [IDX_W:0]   r_head;
    logic [IDX_W:0]   r_tail;

    logic             w_full;
    logic             w_alloc;
    logic [IDX_W-1:0] w_h0;
    logic             w_c0;
    logic             w_c1;
    logic             w_fl0;
    logic             w_fl1;
    logic [IDX_W:0]   w_head_nxt;
    logic [4:0]       w_s1_rd;
    logic [31:0]      w_s1_data;
    logic             w_s1_we;
    logic [IDX_W-1:0] w_s1_idx;
    logic [31:0]      w_s1_pcn;
    logic [IDX_W-1:0] w_wb_idx [WB_PORTS];
    logic             w_unused_pc;

    // The instruction PC travels with dispatch for tracing; redirects use pc_new.
    assign w_unused_pc = ^rob.alloc_pc;

    assign w_full  = (r_head[IDX_W] != r_tail[IDX_W]) &&
                     (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]);
    assign w_alloc = rob.alloc_valid && !w_full;
    assign w_h0    = r_head[IDX_W-1:0];
    assign w_c0    = (r_state[w_h0] == ST_DONE);
    assign w_fl0   = w_c0 && r_misp[w_h0];

`ifdef ROB_DUAL_COMMIT_EN
    logic [IDX_W-1:0] w_h1;
    assign w_h1      = w_h0 + IDX_W'(1);
    assign w_c1      = w_c0 && !r_misp[w_h0] && (r_state[w_h1] == ST_DONE);
    assign w_fl1     = w_c1 && r_misp[w_h1];
    assign w_s1_rd   = w_c1 ? r_rd[w_h1]     : 5'd0;
    assign w_s1_data = w_c1 ? r_data[w_h1]   : 32'd0;
    assign w_s1_we   = w_c1 ? r_we[w_h1]     : 1'b0;
    assign w_s1_idx  = w_c1 ? w_h1           : '0;
    assign w_s1_pcn  = w_fl1 ? r_pc_new[w_h1] : 32'd0;
`else
    assign w_c1      = 1'b0;
    assign w_fl1     = 1'b0;
    assign w_s1_rd   = 5'd0;
    assign w_s1_data = 32'd0;
    assign w_s1_we   = 1'b0;
    assign w_s1_idx  = '0;
    assign w_s1_pcn  = 32'd0;
`endif

    assign w_head_nxt = r_head + {{IDX_W{1'b0}}, w_c0} + {{IDX_W{1'b0}}, w_c1};

    for (genvar k = 0; k < WB_PORTS; k++) begin : g_wb
        assign w_wb_idx[k] = rob.wb_idx[k*IDX_W +: IDX_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i]  <= ST_EMPTY;
                r_data[i]   <= 32'd0;
                r_rd[i]     <= 5'd0;
                r_we[i]     <= 1'b0;
                r_misp[i]   <= 1'b0;
                r_pc_new[i] <= 32'd0;
            end
            r_head <= '0;
            r_tail <= '0;
        end else begin
            // Ascending channel order: the highest channel to an index wins.
            for (int k = 0; k < WB_PORTS; k++) begin
                if (rob.wb_valid[k] && (r_state[w_wb_idx[k]] != ST_EMPTY)) begin
                    r_state[w_wb_idx[k]]  <= ST_DONE;
                    r_data[w_wb_idx[k]]   <= rob.wb_data[k*32 +: 32];
                    r_misp[w_wb_idx[k]]   <= rob.wb_mispredict[k];
                    r_pc_new[w_wb_idx[k]] <= rob.wb_pc_new[k*32 +: 32];
                end
            end
            if (w_alloc) begin
                r_state[r_tail[IDX_W-1:0]] <= ST_WAIT;
                r_rd[r_tail[IDX_W-1:0]]    <= rob.alloc_rd_addr;
                r_we[r_tail[IDX_W-1:0]]    <= rob.alloc_regf_we;
                r_misp[r_tail[IDX_W-1:0]]  <= 1'b0;
            end
            if (w_c0) r_state[w_h0] <= ST_EMPTY;
            if (w_c1) r_state[w_h0 + IDX_W'(1)] <= ST_EMPTY;
            r_head <= w_head_nxt;
            r_tail <= r_tail + {{IDX_W{1'b0}}, w_alloc};
            // A retired mispredict squashes everything younger, including this cycle's traffic.
            if (w_fl0 || w_fl1) begin
                for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_EMPTY;
                r_tail <= w_head_nxt;
            end
        end
    end

    assign rob.alloc_ready    = !w_full;
    assign rob.alloc_idx      = r_tail[IDX_W-1:0];
    assign rob.commit_valid   = {w_c1, w_c0};
    assign rob.commit_rd_addr = {w_s1_rd, (w_c0 ? r_rd[w_h0] : 5'd0)};
    assign rob.commit_data    = {w_s1_data, (w_c0 ? r_data[w_h0] : 32'd0)};
    assign rob.commit_regf_we = {w_s1_we, (w_c0 ? r_we[w_h0] : 1'b0)};
    assign rob.commit_idx     = {w_s1_idx, (w_c0 ? w_h0 : {IDX_W{1'b0}})};
    assign rob.flush          = w_fl0 || w_fl1;
    assign rob.flush_pc       = w_fl0 ? r_pc_new[w_h0] : w_s1_pcn;

    for (genvar j = 0; j < 2; j++) begin : g_lk
        logic [IDX_W-1:0] w_li;
        assign w_li                  = rob.lk_idx[j*IDX_W +: IDX_W];
        assign rob.lk_ready[j]       = (r_state[w_li] == ST_DONE);
        assign rob.lk_data[j*32 +: 32] = (r_state[w_li] == ST_DONE) ? r_data[w_li] : 32'd0;
    end
endmodule
`default_nettype wire

// File: tb/tb_rob_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_param
// Purpose  : Directed stimulus with a queue-based reorder-buffer model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rob_param;
    localparam int DEPTH = 8;
    localparam int WB    = 4;
    localparam int IDX_W = $clog2(DEPTH);
`ifdef ROB_DUAL_COMMIT_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct {
        int          idx;
        logic [4:0]  rd;
        logic        we;
        logic        done;
        logic [31:0] data;
        logic        misp;
        logic [31:0] pcn;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t q[$];
    int   m_tail = 0;

    always #5 clk = ~clk;

    rob_param_if #(.DEPTH(DEPTH), .WB_PORTS(WB)) bus ();
    rob_param #(.DEPTH(DEPTH), .WB_PORTS(WB)) dut (.clk(clk), .rst(rst), .rob(bus.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find(input int idx);
        foreach (q[i]) if (q[i].idx == idx) return i;
        return -1;
    endfunction

    // Model: the live window is an ordered queue, oldest first.
    always @(posedge clk or posedge rst) begin : mdl
        int   occ, nc, last, p;
        bit   fl;
        ent_t e;
        if (rst) begin
            q.delete();
            m_tail = 0;
        end else begin
            occ = q.size(); nc = 0; fl = 0; last = 0;
            if (occ > 0 && q[0].done) begin nc = 1; fl = q[0].misp; last = q[0].idx; end
            if (DUAL && nc == 1 && !fl && occ > 1 && q[1].done) begin
                nc = 2; fl = q[1].misp; last = q[1].idx;
            end
            for (int k = 0; k < WB; k++) begin
                if (bus.wb_valid[k]) begin
                    p = find(int'(bus.wb_idx[k*IDX_W +: IDX_W]));
                    if (p >= 0) begin
                        e = q[p];
                        e.done = 1'b1;
                        e.data = bus.wb_data[k*32 +: 32];
                        e.misp = bus.wb_mispredict[k];
                        e.pcn  = bus.wb_pc_new[k*32 +: 32];
                        q[p] = e;
                    end
                end
            end
            for (int c = 0; c < nc; c++) void'(q.pop_front());
            if (fl) begin
                q.delete();
                m_tail = (last + 1) % DEPTH;
            end else if (bus.alloc_valid && occ < DEPTH) begin
                e.idx = m_tail; e.rd = bus.alloc_rd_addr; e.we = bus.alloc_regf_we;
                e.done = 1'b0; e.data = 32'd0; e.misp = 1'b0; e.pcn = 32'd0;
                q.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [1:0]         ecv, ewe, elr;
        logic [9:0]         erd;
        logic [63:0]        edat, eld;
        logic [2*IDX_W-1:0] eci;
        logic               efl;
        logic [31:0]        efpc;
        int                 p;
        ecv = '0; ewe = '0; elr = '0; erd = '0; edat = '0; eld = '0; eci = '0; efl = 0; efpc = '0;
        if (q.size() > 0 && q[0].done) begin
            ecv[0] = 1'b1; erd[4:0] = q[0].rd; ewe[0] = q[0].we; edat[31:0] = q[0].data;
            eci[IDX_W-1:0] = IDX_W'(q[0].idx);
            if (q[0].misp) begin efl = 1'b1; efpc = q[0].pcn; end
        end
        if (DUAL && ecv[0] && !q[0].misp && q.size() > 1 && q[1].done) begin
            ecv[1] = 1'b1; erd[9:5] = q[1].rd; ewe[1] = q[1].we; edat[63:32] = q[1].data;
            eci[2*IDX_W-1:IDX_W] = IDX_W'(q[1].idx);
            if (q[1].misp) begin efl = 1'b1; efpc = q[1].pcn; end
        end
        for (int j = 0; j < 2; j++) begin
            p = find(int'(bus.lk_idx[j*IDX_W +: IDX_W]));
            if (p >= 0 && q[p].done) begin elr[j] = 1'b1; eld[j*32 +: 32] = q[p].data; end
        end
        chk("alloc_ready", 64'(bus.alloc_ready), 64'(q.size() < DEPTH));
        chk("alloc_idx", 64'(bus.alloc_idx), 64'(m_tail));
        chk("commit_valid", 64'(bus.commit_valid), 64'(ecv));
        chk("commit_rd_addr", 64'(bus.commit_rd_addr), 64'(erd));
        chk("commit_data", bus.commit_data, edat);
        chk("commit_regf_we", 64'(bus.commit_regf_we), 64'(ewe));
        chk("commit_idx", 64'(bus.commit_idx), 64'(eci));
        chk("flush", 64'(bus.flush), 64'(efl));
        chk("flush_pc", 64'(bus.flush_pc), 64'(efpc));
        chk("lk_ready", 64'(bus.lk_ready), 64'(elr));
        chk("lk_data", bus.lk_data, eld);
    end

    task automatic tick();
        @(posedge clk); #1;
        bus.alloc_valid   = 1'b0;
        bus.wb_valid      = '0;
        bus.wb_mispredict = '0;
    endtask

    task automatic al(input logic [4:0] rd);
        bus.alloc_valid   = 1'b1;
        bus.alloc_rd_addr = rd;
        bus.alloc_regf_we = rd[0];
        bus.alloc_pc      = 32'h100 + 32'(rd);
    endtask

    task automatic wb(input int ch, input int idx, input logic [31:0] d,
                      input logic m, input logic [31:0] pn);
        bus.wb_valid[ch]              = 1'b1;
        bus.wb_idx[ch*IDX_W +: IDX_W] = IDX_W'(idx);
        bus.wb_data[ch*32 +: 32]      = d;
        bus.wb_mispredict[ch]         = m;
        bus.wb_pc_new[ch*32 +: 32]    = pn;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick();
        rst = 1'b0; tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.alloc_valid = 0; bus.alloc_rd_addr = 0; bus.alloc_regf_we = 0; bus.alloc_pc = 0;
        bus.wb_valid = 0; bus.wb_idx = 0; bus.wb_data = 0; bus.wb_mispredict = 0; bus.wb_pc_new = 0;
        bus.lk_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst alloc_ready", 64'(bus.alloc_ready), 64'd1);
        chk("rst alloc_idx", 64'(bus.alloc_idx), 64'd0);
        chk("rst commit_valid", 64'(bus.commit_valid), 64'd0);
        chk("rst flush", 64'(bus.flush), 64'd0);
        rst = 1'b0; tick();

        // First retirement after a single writeback.
        al(1); tick(); al(2); tick(); al(3); tick();
        chk("alloc3 idx", 64'(bus.alloc_idx), 64'd3);
        wb(0, 0, 32'h11, 1'b0, 32'h0); tick();
        chk("c0 valid", 64'(bus.commit_valid), 64'd1);
        chk("c0 rd", 64'(bus.commit_rd_addr[4:0]), 64'd1);
        chk("c0 data", 64'(bus.commit_data[31:0]), 64'h11);
        tick();

        // Fill, overflow attempt, commit while full, wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            al(5'(i)); tick();
            chk("fill idx", 64'(bus.alloc_idx), 64'((i + 1) % DEPTH));
        end
        chk("full ready", 64'(bus.alloc_ready), 64'd0);
        al(5'd20); tick();
        chk("ovf idx", 64'(bus.alloc_idx), 64'd0);
        chk("ovf ready", 64'(bus.alloc_ready), 64'd0);
        wb(0, 0, 32'h55, 1'b0, 32'h0); tick();
        chk("full commit", 64'(bus.commit_valid), 64'd1);
        chk("full commit ready", 64'(bus.alloc_ready), 64'd0);
        al(5'd21); tick();
        chk("freed ready", 64'(bus.alloc_ready), 64'd1);
        chk("freed idx", 64'(bus.alloc_idx), 64'd0);
        al(5'd22); tick();
        chk("wrap idx", 64'(bus.alloc_idx), 64'd1);
        chk("wrap full", 64'(bus.alloc_ready), 64'd0);

        // Out-of-order writebacks retire in order.
        do_reset();
        al(4); tick(); al(5); tick(); al(6); tick();
        wb(3, 2, 32'h22, 1'b0, 0); wb(2, 1, 32'h21, 1'b0, 0); wb(1, 0, 32'h20, 1'b0, 0); tick();
`ifdef ROB_DUAL_COMMIT_EN
        chk("ooo cv", 64'(bus.commit_valid), 64'd3);
        chk("ooo cidx", 64'(bus.commit_idx), 64'h08);
        chk("ooo data", bus.commit_data, 64'h00000021_00000020);
        al(7); tick();
        chk("ooo cv2", 64'(bus.commit_valid), 64'd1);
        chk("ooo cidx2", 64'(bus.commit_idx), 64'd2);
        chk("ooo alloc idx", 64'(bus.alloc_idx), 64'd4);
        tick();
`else
        chk("ooo cidx0", 64'(bus.commit_idx), 64'd0);
        chk("ooo data0", 64'(bus.commit_data[31:0]), 64'h20);
        al(7); tick();
        chk("ooo cidx1", 64'(bus.commit_idx), 64'd1);
        chk("ooo data1", 64'(bus.commit_data[31:0]), 64'h21);
        chk("ooo alloc idx", 64'(bus.alloc_idx), 64'd4);
        tick();
        chk("ooo cidx2", 64'(bus.commit_idx), 64'd2);
        chk("ooo data2", 64'(bus.commit_data[31:0]), 64'h22);
        tick();
`endif
        chk("ooo drained", 64'(bus.commit_valid), 64'd0);

        // Mispredict on entry 1 squashes 2..4.
        do_reset();
        for (int i = 1; i <= 5; i++) begin al(5'(i)); tick(); end
        wb(0, 0, 32'h30, 1'b0, 0); wb(1, 1, 32'h31, 1'b1, 32'h1000);
        wb(2, 2, 32'h32, 1'b0, 0); wb(3, 3, 32'h33, 1'b0, 0); tick();
`ifdef ROB_DUAL_COMMIT_EN
        chk("misp cv", 64'(bus.commit_valid), 64'd3);
`else
        chk("pre-misp flush", 64'(bus.flush), 64'd0);
        tick();
        chk("misp cidx", 64'(bus.commit_idx[IDX_W-1:0]), 64'd1);
`endif
        chk("misp flush", 64'(bus.flush), 64'd1);
        chk("misp pc", 64'(bus.flush_pc), 64'h1000);
        al(9); wb(0, 4, 32'h34, 1'b0, 0); tick();
        chk("post-flush cv", 64'(bus.commit_valid), 64'd0);
        chk("post-flush idx", 64'(bus.alloc_idx), 64'd2);
        chk("post-flush flush", 64'(bus.flush), 64'd0);
        repeat (3) tick();
        chk("squashed", 64'(bus.commit_valid), 64'd0);

        // Same-index writeback collision, no bypass, writeback to an empty slot.
        do_reset();
        for (int i = 0; i < 6; i++) begin al(5'(i + 8)); tick(); end
        wb(0, 5, 32'hA, 1'b0, 0); wb(3, 5, 32'hB, 1'b0, 0); wb(1, 7, 32'h77, 1'b0, 0);
        bus.lk_idx = {IDX_W'(7), IDX_W'(5)};
        #1;
        chk("no bypass", 64'(bus.lk_ready), 64'd0);
        tick();
        chk("lk ready", 64'(bus.lk_ready), 64'd1);
        chk("lk data", bus.lk_data, 64'hB);

        // Reset with six completed entries in flight.
        wb(0, 1, 32'h41, 1'b0, 0); wb(1, 2, 32'h42, 1'b0, 0);
        wb(2, 3, 32'h43, 1'b0, 0); wb(3, 4, 32'h44, 1'b0, 0); tick();
        wb(0, 0, 32'h40, 1'b0, 0); tick();
        chk("six done cv", 64'(bus.commit_valid[0]), 64'd1);
        rst = 1'b1; #1;
        chk("arst cv", 64'(bus.commit_valid), 64'd0);
        chk("arst ready", 64'(bus.alloc_ready), 64'd1);
        chk("arst idx", 64'(bus.alloc_idx), 64'd0);
        chk("arst lk", 64'(bus.lk_ready), 64'd0);
        tick(); rst = 1'b0; tick(); tick();
        chk("post-rst cv", 64'(bus.commit_valid), 64'd0);
        al(3); tick();
        chk("post-rst alloc", 64'(bus.alloc_idx), 64'd1);
        chk("post-rst cv2", 64'(bus.commit_valid), 64'd0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rob_param.md
ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 SHALL have parameter DEPTH, default 32, entry count; power of two, 4..64; IDX_W = log2(DEPTH).
REQ-002 SHALL have parameter WB_PORTS, default 4, writeback channels (alu, mul, br, mem order).
REQ-003 SHALL have ports clk input 1 clock and rst input 1 reset; one clock; reset asynchronous, active-high.
REQ-004 SHALL have alloc_valid input 1, dispatch requests entry; alloc_ready output 1, entry free.
REQ-005 SHALL have alloc_rd_addr input 5, alloc_regf_we input 1, alloc_pc input 32: payload of new entry.
REQ-006 SHALL have alloc_idx output IDX_W, index granted to the current allocation (tail pointer).
REQ-007 SHALL have wb_valid input WB_PORTS, wb_idx input WB_PORTS*IDX_W, wb_data input WB_PORTS*32: result channels.
REQ-008 SHALL have wb_mispredict input WB_PORTS, wb_pc_new input WB_PORTS*32: branch outcome per channel.
REQ-009 SHALL have lk_idx input 2*IDX_W, lk_ready output 2, lk_data output 64: dispatch operand lookup.
REQ-010 SHALL have commit_valid output 2, commit_rd_addr output 10, commit_data output 64, commit_regf_we output 2, commit_idx output 2*IDX_W (slot 0 = oldest).
REQ-011 SHALL have flush output 1 and flush_pc output 32: redirect on retired mispredict.

Function
REQ-012 Entry states: EMPTY, WAIT (allocated), DONE (written back); mispredict flag and pc_new stored per entry.
REQ-013 Head/tail pointers IDX_W+1 bits; empty = pointers equal; full = low bits equal, MSB differs; wrap modulo DEPTH.
REQ-014 alloc_ready = not full; allocation on alloc_valid & alloc_ready at clock edge, entry -> WAIT, tail+1.
REQ-015 Allocation when full SHALL be ignored with no state change.
REQ-016 Writeback on wb_valid[k] SHALL set entry wb_idx[k] to DONE with data/flags at the edge; all WB_PORTS channels accepted same cycle.
REQ-017 Writeback to an EMPTY entry SHALL be ignored; two channels to the same index same cycle: highest channel number wins.
REQ-018 lk_ready[j] = entry DONE (combinational from registered state); lk_data = stored data; no same-cycle writeback bypass.
REQ-019 Commit slot 0 SHALL be asserted combinationally when head entry is DONE; entry freed and head+1 at edge.
REQ-020 Committing entry with mispredict flag SHALL assert flush and flush_pc = its pc_new for that cycle; at edge all entries -> EMPTY, tail = head+1, younger allocation and writebacks that cycle discarded.
REQ-021 Allocation and commit in same cycle when full SHALL not allocate (alloc_ready already low).
REQ-022 Allocation and commit in same cycle otherwise SHALL both take effect; occupancy unchanged.
REQ-023 Commit latency: writeback at edge N -> commit_valid visible in cycle N+1 (if at head).

Reset
REQ-024 rst high SHALL asynchronously clear all entries to EMPTY, head = tail = 0.
REQ-025 During/after reset: alloc_ready 1, alloc_idx 0, commit_valid 0, flush 0, flush_pc 0, lk_ready 0, all data outputs 0.
REQ-026 Reset mid-operation SHALL discard all in-flight entries without commit.

Configuration
REQ-027 Macro ROB_DUAL_COMMIT_EN defined: slot 1 commits head+1 in same cycle when slot 0 commits, head+1 DONE, and slot 0 not mispredicted; head advances 2.
REQ-028 Macro undefined: commit_valid[1] tied 0, slot 1 outputs 0, at most one commit per cycle.

Verification
REQ-029 Reset, allocate 3 (rd 1,2,3), writeback idx 0 data 0x11 -> next cycle commit_valid[0]=1, commit_rd_addr=1, commit_data=0x11.
REQ-030 Allocate DEPTH entries -> alloc_ready=0 after DEPTH-th; extra alloc_valid ignored; commit one -> alloc_ready=1, next alloc_idx=0 (wrap).
REQ-031 Writebacks to idx 2,1,0 out of order on channels 3,2,1 same cycle -> commits in order 0,1,2 (one per cycle without macro, 0+1 then 2 with ROB_DUAL_COMMIT_EN).
REQ-032 Entry 1 mispredict pc_new 0x1000, entries 0..4 allocated -> at commit of 1 flush=1, flush_pc=0x1000; next cycle empty, entries 2..4 never commit.
REQ-033 Channels 0 and 3 write idx 5 with 0xA / 0xB same cycle -> lk_idx=5 returns lk_ready=1, lk_data=0xB next cycle.
REQ-034 Assert rst mid-stream with 6 DONE entries -> commit_valid=0 immediately, alloc_ready=1, alloc_idx=0, no commits after release until new allocation.
